// File: rtl/sort_sequencer_if.sv
// Stream bundle for sort_sequencer: valid/ready word input, valid/ready sorted output, busy flag.
interface sort_sequencer_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sort_sequencer.sv
// Frame sorter: loads N words, bubble-sorts them with one compare-exchange unit
// over N(N-1)/2 cycles, then streams them out smallest first.
module sort_sequencer #(
    parameter int N = 5,
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst,
    sort_sequencer_if.slave    bus
);
    localparam int KW = (N > 2) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_IDX = KW'(N - 1);
    localparam logic [KW-1:0] LAST_PASS = KW'(N - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_reg;
    logic [KW-1:0]   p_reg;
    logic [KW-1:0]   i_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic            busy_reg;
    logic [W-1:0]    r_reg  [N];
    logic [W-1:0]    r_next [N];

    logic [W-1:0]    lo_word;
    logic [W-1:0]    hi_word;
    logic            do_swap;
    logic            accept;

    // Single compare-exchange unit, steered by the index counter.
    assign lo_word = r_reg[i_reg];
    assign hi_word = r_reg[i_reg + KW'(1)];
    assign do_swap = (state_reg == SORT) && (lo_word > hi_word);
    assign accept  = (state_reg == LOAD) && bus.in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_word
            logic load_here;
            logic swap_from_hi;
            logic swap_from_lo;

            assign load_here    = accept && (k_reg == KW'(gi));
            assign swap_from_hi = do_swap && (gi < N - 1) && (i_reg == KW'(gi));
            if (gi > 0) begin : g_lo
                assign swap_from_lo = do_swap && (i_reg == KW'(gi - 1));
            end else begin : g_nolo
                assign swap_from_lo = 1'b0;
            end

            assign r_next[gi] = load_here    ? bus.in_data :
                                swap_from_hi ? hi_word     :
                                swap_from_lo ? lo_word     :
                                               r_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg <= '{default: '0};
        end else begin
            r_reg <= r_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD;
            k_reg         <= '0;
            p_reg         <= '0;
            i_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (k_reg == LAST_IDX) begin
                            k_reg        <= '0;
                            p_reg        <= '0;
                            i_reg        <= '0;
                            state_reg    <= SORT;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                        end else begin
                            k_reg <= k_reg + KW'(1);
                        end
                    end
                end
                SORT: begin
                    // End of a pass: the tail beyond N-2-p is already in final order.
                    if (i_reg == LAST_PASS - p_reg) begin
                        i_reg <= '0;
                        if (p_reg == LAST_PASS) begin
                            p_reg         <= '0;
                            state_reg     <= DRAIN;
                            out_valid_reg <= 1'b1;
                        end else begin
                            p_reg <= p_reg + KW'(1);
                        end
                    end else begin
                        i_reg <= i_reg + KW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (k_reg == LAST_IDX) begin
                            k_reg         <= '0;
                            state_reg     <= LOAD;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            in_ready_reg  <= 1'b1;
                        end else begin
                            k_reg <= k_reg + KW'(1);
                        end
                    end
                end
                default: begin
                    state_reg     <= LOAD;
                    k_reg         <= '0;
                    p_reg         <= '0;
                    i_reg         <= '0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.out_data  = out_valid_reg ? r_reg[k_reg] : '0;
endmodule
